// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the device: it inhibits the bus, signals
// request-to-send, shifts the frame out on clocks generated by the device,
// then checks the device acknowledge. busy lets the top level gate the PS/2
// receiver that shares the same lines.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    // One shared counter times inhibit, request-to-send and the frame
    // timeout, so it is sized for the largest of the three.
    localparam int MAX_A  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_B  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_B + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       STOP_IDX     = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [7:0]       r_byte;
    logic [7:0]       w_byte_nxt;
    logic             r_par;
    logic             w_par_nxt;
    logic             r_clk_oe;
    logic             w_clk_oe_nxt;
    logic             r_data_oe;
    logic             w_data_oe_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    logic             r_clk_meta;
    logic             r_clk_sync;
    logic             r_clk_dly;
    logic             r_data_meta;
    logic             r_data_sync;

    logic             w_neg_edge;
    logic             w_accept;
    logic [9:0]       w_frame;

    // Two-flop synchronizers for the asynchronous bus lines, plus a delayed
    // copy of the synced clock for falling-edge detection.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_clk_meta  <= 1'b0;
            r_clk_sync  <= 1'b0;
            r_clk_dly   <= 1'b0;
            r_data_meta <= 1'b0;
            r_data_sync <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_dly   <= r_clk_sync;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    // The synced lines reset low, so tx_ready stays low after reset until
    // both lines have actually been seen high.
    assign w_neg_edge = r_clk_dly & ~r_clk_sync;
    assign tx_ready   = (r_state == ST_IDLE) & r_clk_sync & r_data_sync;
    assign w_accept   = tx_valid & tx_ready;
    // Frame bits 0-7 data LSB first, 8 parity, 9 stop (always 1).
    assign w_frame    = {1'b1, r_par, r_byte};

    // State, counter and registered-output update; reset releases the lines
    // asynchronously.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= 4'd0;
            r_byte    <= 8'h00;
            r_par     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_byte    <= w_byte_nxt;
            r_par     <= w_par_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode for the transmit sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_byte_nxt    = r_byte;
        w_par_nxt     = r_par;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = r_data_oe;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_data_oe_nxt = 1'b0;
                w_cnt_nxt     = '0;
                w_idx_nxt     = 4'd0;
                if (w_accept) begin
                    w_byte_nxt   = tx_data;
                    w_par_nxt    = odd_parity(tx_data);
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = ST_INHIBIT;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end

            ST_INHIBIT: begin
                w_clk_oe_nxt  = 1'b1;
                w_data_oe_nxt = 1'b0;
                if (r_cnt == INHIBIT_LAST) begin
                    // Start bit: pull data low while the clock is still held.
                    w_cnt_nxt     = '0;
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = ST_RTS;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end

            ST_RTS: begin
                w_clk_oe_nxt  = 1'b1;
                w_data_oe_nxt = 1'b1;
                if (r_cnt == RTS_LAST) begin
                    // Release the clock; from here the counter is the timeout.
                    w_clk_oe_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = 4'd0;
                    w_state_nxt  = ST_SEND;
                end else begin
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                end
            end

            ST_SEND: begin
                if (r_cnt == TIMEOUT_LAST) begin
                    w_data_oe_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_neg_edge) begin
                        w_data_oe_nxt = ~w_frame[r_idx];
                        if (r_idx == STOP_IDX) begin
                            w_idx_nxt   = 4'd0;
                            w_state_nxt = ST_ACK;
                        end else begin
                            w_idx_nxt   = r_idx + 4'd1;
                        end
                    end else begin
                        w_idx_nxt = r_idx;
                    end
                end
            end

            ST_ACK: begin
                w_data_oe_nxt = 1'b0;
                if (r_cnt == TIMEOUT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_neg_edge) begin
                        if (r_data_sync) begin
                            // Device left data high: NACK.
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_WAIT_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (r_cnt == TIMEOUT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_clk_sync && r_data_sync) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
            end

            default: begin
                w_data_oe_nxt = 1'b0;
                w_cnt_nxt     = '0;
                w_idx_nxt     = 4'd0;
                w_state_nxt   = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign busy        = r_busy;

endmodule
